// File: rtl/reg_file_param.sv
// Parameterised two-write, two-read register file with a per-register pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-edge writes and scoreboard updates to the read ports.
module reg_file_param #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            re,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            we0,
   input  logic            we1,
   input  logic [AW-1:0]   wa0,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd0,
   input  logic [XLEN-1:0] wd1,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_wa
);

   logic [XLEN-1:0] mem_r [NREG];
   logic [NREG-1:0] pend_r;
   logic [NREG-1:0] pend_nxt_s;
   logic [XLEN-1:0] rd1_r, rd2_r, rdat1_s, rdat2_s;
   logic            busy1_r, busy2_r, bsy1_s, bsy2_s;

`ifdef REG_FILE_BYPASS_EN
   // Value register ra will hold after this edge; port 1 wins a write collision.
   function automatic logic [XLEN-1:0] fwd_data(
      input logic [AW-1:0]   ra,
      input logic [XLEN-1:0] cur,
      input logic            w0,
      input logic [AW-1:0]   a0,
      input logic [XLEN-1:0] d0,
      input logic            w1,
      input logic [AW-1:0]   a1,
      input logic [XLEN-1:0] d1
   );
      logic [XLEN-1:0] v;
      if (ra == {AW{1'b0}}) v = {XLEN{1'b0}};
      else if (w1 && (a1 == ra)) v = d1;
      else if (w0 && (a0 == ra)) v = d0;
      else v = cur;
      return v;
   endfunction
`endif

   // Scoreboard next state: clears from writes, then issue set overrides.
   always_comb begin
      pend_nxt_s = pend_r;
      pend_nxt_s[wa0] = pend_nxt_s[wa0] & ~we0;
      pend_nxt_s[wa1] = pend_nxt_s[wa1] & ~we1;
      pend_nxt_s[iss_wa] = pend_nxt_s[iss_wa] | iss_en;
      pend_nxt_s[0] = 1'b0;
   end

   // Read-port source selection (forwarded or pre-edge state).
   always_comb begin
`ifdef REG_FILE_BYPASS_EN
      rdat1_s = fwd_data(ra1, mem_r[ra1], we0, wa0, wd0, we1, wa1, wd1);
      rdat2_s = fwd_data(ra2, mem_r[ra2], we0, wa0, wd0, we1, wa1, wd1);
      bsy1_s  = pend_nxt_s[ra1];
      bsy2_s  = pend_nxt_s[ra2];
`else
      rdat1_s = mem_r[ra1];
      rdat2_s = mem_r[ra2];
      bsy1_s  = pend_r[ra1];
      bsy2_s  = pend_r[ra2];
`endif
   end

   // Register storage; entry 0 is never written, so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem_r[i] <= {XLEN{1'b0}};
      end else begin
         if (we0 && (wa0 != {AW{1'b0}})) mem_r[wa0] <= wd0;
         if (we1 && (wa1 != {AW{1'b0}})) mem_r[wa1] <= wd1;
      end
   end

   // Pending scoreboard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_r <= {NREG{1'b0}};
      else        pend_r <= pend_nxt_s;
   end

   // Registered read outputs; re=0 stalls them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1_r   <= {XLEN{1'b0}};
         rd2_r   <= {XLEN{1'b0}};
         busy1_r <= 1'b0;
         busy2_r <= 1'b0;
      end else if (re) begin
         rd1_r   <= rdat1_s;
         rd2_r   <= rdat2_s;
         busy1_r <= bsy1_s;
         busy2_r <= bsy2_s;
      end
   end

   assign rd1   = rd1_r;
   assign rd2   = rd2_r;
   assign busy1 = busy1_r;
   assign busy2 = busy2_r;

endmodule
